// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the data-memory responder and its decode.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    localparam int WORD_BYTES = 4;

    // ALU memory opcodes, kept here so execute-stage decode matches the responder.
    localparam logic [3:0] LW = 4'd11;
    localparam logic [3:0] SW = 4'd12;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM: registered read with read enable, no reset.
// Read data holds its last value while read enable is low.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Level-request load/store responder: one access at a time, fixed latency, single-cycle
// mem_ready pulse; a held request is drained before the next one can be accepted.
module data_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        busy
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS * WORD_BYTES);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    op_e                op_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        rd_reg;
    logic               use_ram;

    logic [32:0]        offset;
    logic               req;
    logic               legal;
    logic               accept;
    logic               ram_re;
    logic               ram_we;
    logic [IDX_W-1:0]   acc_idx;
    logic [IDX_W-1:0]   ram_addr;
    logic [31:0]        ram_q;
    logic               resp_err;
    logic               resp_store;
    logic [31:0]        resp_wdata;
    logic               enter_resp;

    // 33-bit subtract: a borrow into bit 32 means the address is below BASE_ADDR.
    assign offset  = {1'b0, mem_address} - {1'b0, BASE_ADDR};
    assign req     = mem_read | mem_write;
    assign legal   = !(mem_read && mem_write) && (mem_address[1:0] == 2'b00)
                     && !offset[32] && (offset < SPAN);
    assign acc_idx = offset[IDX_W+1:2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    ram_re = legal && mem_read;
                    if (!legal || LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Response content comes from the live inputs when RESP is entered straight from IDLE.
    assign resp_err   = (state == IDLE) ? !legal     : err_q;
    assign resp_store = (state == IDLE) ? mem_write  : (op_q == OP_STORE);
    assign resp_wdata = (state == IDLE) ? write_data : wdata_q;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    assign ram_we   = (state == RESP) && (op_q == OP_STORE) && !err_q && !rst;
    assign ram_addr = (state == IDLE) ? acc_idx : idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            busy      <= 1'b0;
            rd_reg    <= 32'd0;
            use_ram   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy      <= (state_nxt != IDLE);
            mem_ready <= enter_resp;
            mem_error <= enter_resp && resp_err;
            if (enter_resp) begin
                if (resp_err) begin
                    rd_reg  <= 32'd0;
                    use_ram <= 1'b0;
                end else if (resp_store) begin
                    rd_reg  <= resp_wdata;
                    use_ram <= 1'b0;
                end else begin
                    use_ram <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= mem_write ? OP_STORE : OP_LOAD;
            idx_q   <= acc_idx;
            wdata_q <= write_data;
            err_q   <= !legal;
        end
    end

    // Load data stays in the RAM output register, which only reloads on a load acceptance.
    assign read_data = use_ram ? ram_q : rd_reg;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_dmem_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with default parameters (LATENCY=2, 1024 words, base 0).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_ready;
    logic        mem_error;
    logic        busy;

    int total = 0;
    int bad   = 0;

    data_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .write_data  (write_data),
        .read_data   (read_data),
        .mem_ready   (mem_ready),
        .mem_error   (mem_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled on falling edges.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int lat     = 0;
        int pulses  = 0;
        int waited  = 0;
        logic        err_seen = 1'bx;
        logic [31:0] rd_seen  = 'x;
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        write_data  = wd;
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            if (c == 2) begin
                // Inputs after acceptance must be ignored.
                mem_address = 32'h0000_0080;
                write_data  = 32'h0BAD_0BAD;
            end
            if (mem_ready) begin
                pulses++;
                if (lat == 0) begin
                    lat      = c;
                    err_seen = mem_error;
                    rd_seen  = read_data;
                end
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        while (busy && waited < 20) begin
            @(negedge clk);
            waited++;
            if (mem_ready) pulses++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, {31'd0, err_seen}, {31'd0, exp_err});
        chk({tag, "_rdata"}, rd_seen, exp_rd);
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_rdata_hold"}, read_data, exp_rd);
        chk({tag, "_drained"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 32'd0;
        write_data  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_error", {31'd0, mem_error}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_rdata", read_data,          32'd0);

        // Store held for 6 cycles: exactly one response, read_data echoes the store.
        do_req("st10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 6, 2, 1'b0, 32'hDEAD_BEEF);
        do_req("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 3, 2, 1'b0, 32'hDEAD_BEEF);

        do_req("misal", 1'b1, 1'b0, 32'h13, 32'h0, 2, 1, 1'b1, 32'h0);
        do_req("ld10b", 1'b1, 1'b0, 32'h10, 32'h0, 3, 2, 1'b0, 32'hDEAD_BEEF);

        do_req("oor_top", 1'b1, 1'b0, 32'h1000, 32'h0, 2, 1, 1'b1, 32'h0);
        do_req("st_ffc",  1'b0, 1'b1, 32'hFFC, 32'h1234_5678, 3, 2, 1'b0, 32'h1234_5678);
        do_req("ld_ffc",  1'b1, 1'b0, 32'hFFC, 32'h0, 3, 2, 1'b0, 32'h1234_5678);
        do_req("oor_wrap", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 2, 1, 1'b1, 32'h0);

        do_req("st20",  1'b0, 1'b1, 32'h20, 32'h5, 3, 2, 1'b0, 32'h5);
        do_req("both",  1'b1, 1'b1, 32'h20, 32'hFFFF_0000, 2, 1, 1'b1, 32'h0);
        do_req("ld20",  1'b1, 1'b0, 32'h20, 32'h0, 3, 2, 1'b0, 32'h5);

        // Store aborted by reset while waiting must not commit.
        do_req("st40",  1'b0, 1'b1, 32'h40, 32'h1, 3, 2, 1'b0, 32'h1);
        mem_write   = 1'b1;
        mem_address = 32'h40;
        write_data  = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("abort_busy_wait", {31'd0, busy}, 32'd1);
        rst       = 1'b1;
        mem_write = 1'b0;
        begin
            int rdy_cnt = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (mem_ready) rdy_cnt++;
            end
            chk("abort_no_ready", 32'(rdy_cnt), 32'd0);
        end
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_req("ld40", 1'b1, 1'b0, 32'h40, 32'h0, 3, 2, 1'b0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
